requant_pipe: RTL and testbench
===============================

# requant_pipe

Streaming, multi-lane, per-channel requantizer that converts wide signed accumulator results into narrow signed activations for the next layer. It replaces the combinational divide-and-clip quantizer with a fixed-point scale (multiplier plus arithmetic right shift), round-half-up, and saturation. It sits between the accumulator drain and the activation write-back buffer, and uses a valid/ready handshake with full backpressure. It also keeps a saturation-event counter for calibration.

## Interface
- IN_W, 32: signed accumulator width per lane
- OUT_W, 8: signed output width per lane
- MULT_W, 16: unsigned scale multiplier width
- SHIFT_W, 6: shift amount width
- LANES, 4: lanes processed per beat
- CH, 16: scale-table depth (output channels); CH_W = clog2(CH)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  scale-table write strobe
- cfg_addr  in  CH_W  table entry to write
- cfg_mult  in  MULT_W  multiplier value (unsigned)
- cfg_shift  in  SHIFT_W  right-shift value
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat this cycle
- s_data  in  LANES*IN_W  signed accumulators; lane i is at bits [i*IN_W +: IN_W]
- s_ch  in  CH_W  channel index selecting the table entry for the whole beat
- s_last  in  1  end-of-tile marker, passed through unchanged
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the beat
- m_data  out  LANES*OUT_W  quantized lanes, same lane order as s_data
- m_last  out  1  delayed copy of s_last
- sat_clr  in  1  clears sat_cnt
- sat_cnt  out  16  number of lanes clipped since the last clear; saturates at 0xFFFF

## Operation
- Per lane: p = x * mult, a signed IN_W by unsigned MULT_W multiply giving an IN_W+MULT_W+1 bit result.
- Rounding:
  - If shift > 0: r = (p + (1 << (shift-1))) >>> shift.
  - If shift = 0: r = p.
  - Use enough guard bits that the rounding add never overflows.
- Saturation:
  - If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1.
  - If r < -2^(OUT_W-1), output -2^(OUT_W-1).
  - Otherwise output r truncated to OUT_W bits.
  - Each clipped lane is one saturation event.
- mult = 0 forces every lane of the beat to 0 and counts no saturation. This is the disabled-scale case.
- Scale table:
  - CH entries of {mult, shift}, written when cfg_we = 1.
  - Every entry resets to {0, 0}.
  - The entry is read when a beat is accepted and travels with that beat.
  - If a write to channel k occurs in the same cycle that a beat with s_ch = k is accepted, the beat uses the old value. The new value applies from the next accepted beat.
- sat_cnt:
  - Adds the clipped-lane count of each beat as the beat leaves the final stage, clamping at 0xFFFF.
  - If sat_clr coincides with an increment, the result is 0 (clear wins).

## Timing
- Three stages:
  - S1: register data, channel scale and last.
  - S2: multiply.
  - S3: round, shift and saturate; its registers drive the m_* outputs.
- Latency: exactly 3 cycles from acceptance to m_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Stall control:
  - en = !m_valid || m_ready, and s_ready = en.
  - When en = 0, every stage holds its contents; m_data and m_last stay stable while m_valid = 1 and m_ready = 0.
  - A beat is accepted when s_valid && s_ready.
  - Stage valid bits propagate when en = 1, and bubbles are passed through.
- Synchronous reset:
  - m_valid = 0, m_data = 0, m_last = 0, sat_cnt = 0.
  - All stage valid bits are cleared and all table entries are set to {0, 0}.
  - s_ready = 1 in the first cycle after reset.
  - A reset during traffic discards in-flight beats; no partial beat is emitted.
- Configuration writes are accepted every cycle regardless of stall state.

## Structure
- Package requant_pkg holds:
  - default parameters;
  - a scale-entry typedef {mult, shift};
  - a localparam for the guard width, IN_W+MULT_W+2;
  - the saturation limit constants as functions of OUT_W.
- Sub-module requant_lane holds one lane of datapath: multiply, round, shift and saturate. It has a stage enable and outputs the clipped flag. It is instantiated LANES times.
- The top level holds the scale table, stage valid/last registers, stall logic and sat_cnt.

## Test plan
- Write ch 0 = {mult 8192, shift 14}, send lane values 100, -100, 255, 0: m_data = 50, -50, 128 clipped to 127, 0; sat_cnt = 1; m_valid 3 cycles after acceptance.
- Write ch 1 = {mult 1, shift 1}, send 3, -3, 1, -1: outputs 2, -1, 1, 0, confirming round-half-up.
- Use ch 2 with mult = 0 (reset value), send 0x7FFFFFFF on all lanes: all outputs 0 and sat_cnt unchanged.
- Stream 20 beats with m_ready toggling in a random pattern: output order, m_last position and data match the model; no beat is lost or duplicated; outputs are stable while stalled.
- Write ch 3 = {2, 0} in the same cycle a ch 3 beat is accepted: that beat uses the old {0, 0} entry and gives 0; the next beat with value 5 gives 10.
- Assert rst_n = 0 with 2 beats in flight: no m_valid afterwards and sat_cnt = 0. Separately, drive sat_clr in the same cycle as a clipping beat: sat_cnt = 0.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg: shared definitions for the requantizer pipeline.
//   - default widths/depths for requant_pipe and requant_lane
//   - scale_t: one scale-table entry {mult, shift}
//   - GUARD_W: rounding-path width (sign + product + one carry bit)
//   - sat_hi / sat_lo: signed clip limits for an OUT_W-bit result
package requant_pkg;

  localparam int IN_W_D    = 32;
  localparam int OUT_W_D   = 8;
  localparam int MULT_W_D  = 16;
  localparam int SHIFT_W_D = 6;
  localparam int LANES_D   = 4;
  localparam int CH_D      = 16;

  localparam int GUARD_W = IN_W_D + MULT_W_D + 2;

  typedef struct packed {
    logic [MULT_W_D-1:0]  mult;
    logic [SHIFT_W_D-1:0] shift;
  } scale_t;

  function automatic longint sat_hi(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of the requantizer datapath.
//   clk, rst_n : clock, synchronous active-low reset (output register only)
//   en         : stage enable; all stages hold when low
//   x          : raw signed accumulator for this lane (captured in S1)
//   mult_p0    : unsigned multiplier, already registered in S1 by the top
//   shift_p1   : shift amount, registered alongside the product in S2
//   q_p2       : saturated signed result (S3)
//   clip_p2    : high when q_p2 was clipped (S3)
module requant_lane
  import requant_pkg::*;
#(
  parameter int IN_W    = IN_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int MULT_W  = MULT_W_D,
  parameter int SHIFT_W = SHIFT_W_D,
  parameter int GW      = GUARD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [IN_W-1:0]   x,
  input  logic        [MULT_W-1:0] mult_p0,
  input  logic       [SHIFT_W-1:0] shift_p1,
  output logic signed [OUT_W-1:0]  q_p2,
  output logic                     clip_p2
);

  localparam int PW = IN_W + MULT_W + 1;
  localparam logic signed [GW-1:0] SAT_HI = GW'(sat_hi(OUT_W));
  localparam logic signed [GW-1:0] SAT_LO = GW'(sat_lo(OUT_W));

  logic signed [IN_W-1:0] x_p0;
  logic signed [PW-1:0]   p_p1;
  logic signed [GW-1:0]   r_p1;

  // Round-half-up then arithmetic shift. Shifts at or beyond the product
  // width always round to zero (|p| < 2^(PW-2)), and short-circuiting them
  // keeps the rounding constant inside the guard width.
  function automatic logic signed [GW-1:0] round_shift(
    input logic signed [PW-1:0]  p,
    input logic [SHIFT_W-1:0]    sh
  );
    logic signed [GW-1:0] pe;
    logic signed [GW-1:0] half;
    pe = GW'(p);
    if (sh == '0) return pe;
    if (int'(sh) >= PW) return '0;
    half = GW'(1) <<< (sh - 1'b1);
    return (pe + half) >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [GW-1:0] r);
    if (r > SAT_HI) return OUT_W'(SAT_HI);
    if (r < SAT_LO) return OUT_W'(SAT_LO);
    return r[OUT_W-1:0];
  endfunction

  function automatic logic is_clip(input logic signed [GW-1:0] r);
    return (r > SAT_HI) || (r < SAT_LO);
  endfunction

  // S1: capture accumulator
  always_ff @(posedge clk) begin
    if (en) x_p0 <= x;
  end

  // S2: signed x unsigned multiply (multiplier zero-extended to stay positive)
  always_ff @(posedge clk) begin
    if (en) p_p1 <= PW'(x_p0) * PW'($signed({1'b0, mult_p0}));
  end

  assign r_p1 = round_shift(p_p1, shift_p1);

  // S3: round, shift, saturate; drives the output lane
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_p2    <= '0;
      clip_p2 <= 1'b0;
    end else if (en) begin
      q_p2    <= saturate(r_p1);
      clip_p2 <= is_clip(r_p1);
    end
  end

endmodule

// File: rtl/requant_pipe.sv
// requant_pipe: streaming per-channel requantizer, LANES lanes per beat,
// three stages, valid/ready with full backpressure.
//   clk, rst_n           : clock, synchronous active-low reset
//   cfg_we/addr/mult/shift: scale-table write port (always accepted)
//   s_valid/s_ready/s_data/s_ch/s_last : input beat
//   m_valid/m_ready/m_data/m_last      : output beat
//   sat_clr, sat_cnt     : clipped-lane counter (saturating at 0xFFFF)
module requant_pipe
  import requant_pkg::*;
#(
  parameter int IN_W    = IN_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int MULT_W  = MULT_W_D,
  parameter int SHIFT_W = SHIFT_W_D,
  parameter int LANES   = LANES_D,
  parameter int CH      = CH_D,
  parameter int CH_W    = $clog2(CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic [MULT_W-1:0]      cfg_mult,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*IN_W-1:0]  s_data,
  input  logic [CH_W-1:0]        s_ch,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*OUT_W-1:0] m_data,
  output logic                   m_last,
  input  logic                   sat_clr,
  output logic [15:0]            sat_cnt
);

  scale_t             tbl [CH];
  scale_t             scl_p0;
  logic [SHIFT_W-1:0] shift_p1;
  logic               vld_p0, vld_p1, vld_p2;
  logic               last_p0, last_p1, last_p2;
  logic [LANES-1:0]   clip_p2;
  logic               en;
  logic [16:0]        sat_sum;

  // A whole-pipeline stall: only a held output blocks progress.
  assign en      = !vld_p2 || m_ready;
  assign s_ready = en;
  assign m_valid = vld_p2;
  assign m_last  = last_p2;

  // The table read for S1 sees the pre-write value on a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= '{mult: cfg_mult, shift: cfg_shift};
    end
  end

  // S1: register valid, channel scale and last
  always_ff @(posedge clk) begin
    if (!rst_n)  vld_p0 <= 1'b0;
    else if (en) vld_p0 <= s_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      scl_p0  <= tbl[s_ch];
      last_p0 <= s_last;
    end
  end

  // S2: multiply stage; shift travels with the product
  always_ff @(posedge clk) begin
    if (!rst_n)  vld_p1 <= 1'b0;
    else if (en) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      shift_p1 <= scl_p0.shift;
      last_p1  <= last_p0;
    end
  end

  // S3: round/saturate stage; registers drive m_*
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .MULT_W  (MULT_W),
      .SHIFT_W (SHIFT_W),
      .GW      (IN_W + MULT_W + 2)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .x        (s_data[i*IN_W +: IN_W]),
      .mult_p0  (scl_p0.mult),
      .shift_p1 (shift_p1),
      .q_p2     (m_data[i*OUT_W +: OUT_W]),
      .clip_p2  (clip_p2[i])
    );
  end

  // Clip events are counted once, when the beat is handed downstream.
  assign sat_sum = {1'b0, sat_cnt} + 17'($countones(clip_p2));

  always_ff @(posedge clk) begin
    if (!rst_n)                sat_cnt <= '0;
    else if (sat_clr)          sat_cnt <= '0;
    else if (vld_p2 && m_ready) sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

endmodule

// File: tb/tb_requant_pipe.sv
module tb_requant_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [15:0]  cfg_mult;
  logic [5:0]   cfg_shift;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic [3:0]   s_ch;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         sat_clr;
  logic [15:0]  sat_cnt;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  bit rand_ready = 1'b0;

  // Reference model state
  logic [31:0]  q_data[$];
  bit           q_last[$];
  int           q_clip[$];
  int unsigned  tbl_m[16];
  int unsigned  tbl_s[16];
  longint       mcnt;
  bit           prev_stall;
  logic [31:0]  prev_data;
  logic         prev_last;

  requant_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_ch      (s_ch),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  initial forever #5 clk = ~clk;

  // Plain integer arithmetic: scale, round half up, shift.
  function automatic longint mdl_round(input longint x, input longint m, input int s);
    longint p;
    p = x * m;
    if (s == 0) return p;
    return (p + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  function automatic logic [7:0] mdl_sat(input longint r);
    if (r > 127)  return 8'h7F;
    if (r < -128) return 8'h80;
    return r[7:0];
  endfunction

  function automatic int mdl_clip(input longint r);
    return (r > 127 || r < -128) ? 1 : 0;
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_lanes(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_lane%0d", nm, i), longint'($signed(m_data[i*8 +: 8])), e[i]);
  endtask

  task automatic cfg_write(input int ch, input int m, input int s);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 4'(ch); cfg_mult = 16'(m); cfg_shift = 6'(s);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_beat(input int ch, input logic [127:0] data, input bit last);
    int n;
    @(posedge clk); #1;
    s_valid = 1'b1; s_ch = 4'(ch); s_data = data; s_last = last;
    n = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (s_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: s_ready=%b want 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) break;
    end
    if (k > 50) begin
      total++; bad++;
      $display("FAIL out_timeout: m_valid=%b want 1", m_valid);
    end
  endtask

  // Output driver for m_ready: random during the streaming phase.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: checks outputs against the model every cycle, then
  // advances the model by what the upcoming clock edge will do.
  always @(negedge clk) begin
    logic [31:0] d;
    int          c;
    longint      r;
    bit          hs;
    int          hs_clip;
    hs = 1'b0;
    hs_clip = 0;
    if (!rst_n) begin
      q_data.delete(); q_last.delete(); q_clip.delete();
      mcnt = 0;
      foreach (tbl_m[i]) begin tbl_m[i] = 0; tbl_s[i] = 0; end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          bad++;
          $display("FAIL hold: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid === 1'b1) begin
        total++;
        if (q_data.size() == 0) begin
          bad++;
          $display("FAIL spurious_beat: data=%h last=%b, no beat expected", m_data, m_last);
        end else begin
          if (m_data !== q_data[0] || m_last !== q_last[0]) begin
            bad++;
            $display("FAIL beat: data=%h last=%b want data=%h last=%b",
                     m_data, m_last, q_data[0], q_last[0]);
          end
          if (m_ready === 1'b1) begin
            hs = 1'b1;
            hs_clip = q_clip[0];
            void'(q_data.pop_front()); void'(q_last.pop_front()); void'(q_clip.pop_front());
            pops++;
          end
        end
      end
      total++;
      if (sat_cnt !== 16'(mcnt)) begin
        bad++;
        $display("FAIL sat_cnt: got %0d want %0d", sat_cnt, mcnt);
      end
      if (sat_clr) mcnt = 0;
      else if (hs) begin
        mcnt = mcnt + hs_clip;
        if (mcnt > 65535) mcnt = 65535;
      end
      if (s_valid && s_ready) begin
        d = '0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
          r = mdl_round(longint'($signed(s_data[i*32 +: 32])), longint'(tbl_m[s_ch]), int'(tbl_s[s_ch]));
          d[i*8 +: 8] = mdl_sat(r);
          c += mdl_clip(r);
        end
        q_data.push_back(d); q_last.push_back(s_last); q_clip.push_back(c);
      end
      if (cfg_we) begin
        tbl_m[cfg_addr] = cfg_mult;
        tbl_s[cfg_addr] = cfg_shift;
      end
      prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    int pops0;
    int ch, m, s;
    int lanes[4];
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mult = '0; cfg_shift = '0;
    s_valid = 1'b0; s_data = '0; s_ch = '0; s_last = 1'b0; sat_clr = 1'b0;

    // Hand-computed values pinning the model
    chk("mdl_pos",  mdl_round(100, 8192, 14), 50);
    chk("mdl_neg",  mdl_round(-100, 8192, 14), -50);
    chk("mdl_clip", longint'($signed(mdl_sat(mdl_round(255, 8192, 14)))), 127);
    chk("mdl_half_neg", mdl_round(-3, 1, 1), -1);
    chk("mdl_half_m1",  mdl_round(-1, 1, 1), 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data",  m_data, 0);
    chk("rst_m_last",  m_last, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_s_ready", s_ready, 1);

    // Basic scale with one clipped lane, latency
    cfg_write(0, 8192, 14);
    send_beat(0, pack4(100, -100, 255, 0), 1'b1);
    wait_out(k);
    chk("t1_latency", k, 3);
    chk_lanes("t1", 50, -50, 127, 0);
    chk("t1_last", m_last, 1);
    @(negedge clk);
    chk("t1_sat_cnt", sat_cnt, 1);

    // Round half up
    cfg_write(1, 1, 1);
    send_beat(1, pack4(3, -3, 1, -1), 1'b0);
    wait_out(k);
    chk_lanes("t2", 2, -1, 1, 0);
    chk("t2_last", m_last, 0);

    // Disabled scale (reset value of ch 2)
    send_beat(2, pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 1'b0);
    wait_out(k);
    chk_lanes("t3", 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_sat_cnt", sat_cnt, 1);

    // Table write in the same cycle as a beat on that channel
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_mult = 16'd2; cfg_shift = 6'd0;
    s_valid = 1'b1; s_ch = 4'd3; s_data = pack4(5, 5, 5, 5); s_last = 1'b0;
    @(negedge clk);
    chk("t5_s_ready", s_ready, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0; s_valid = 1'b0;
    wait_out(k);
    chk_lanes("t5_old", 0, 0, 0, 0);
    send_beat(3, pack4(5, 5, 5, 5), 1'b0);
    wait_out(k);
    chk_lanes("t5_new", 10, 10, 10, 10);

    // Random stream with random backpressure
    for (int c2 = 0; c2 < 4; c2++)
      cfg_write(c2, $urandom_range(1, 65535), $urandom_range(8, 24));
    rand_ready = 1'b1;
    pops0 = pops;
    for (int b = 0; b < 20; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, 3);
        m  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
        s  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(8, 24);
        cfg_write(ch, m, s);
      end
      for (int i = 0; i < 4; i++)
        lanes[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4000)) - 2000 : int'($urandom);
      send_beat($urandom_range(0, 3), pack4(lanes[0], lanes[1], lanes[2], lanes[3]),
                1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int n = 0; n < 300 && q_data.size() != 0; n++) @(negedge clk);
    chk("t4_drained", q_data.size(), 0);
    chk("t4_beats_out", pops - pops0, 20);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with two beats in flight
    cfg_write(0, 8192, 14);
    @(posedge clk); #1;
    s_valid = 1'b1; s_ch = 4'd0; s_data = pack4(255, 255, 255, 255); s_last = 1'b1;
    @(posedge clk); #1;
    s_data = pack4(300, -300, 300, -300);
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk($sformatf("t6_no_valid_%0d", n), m_valid, 0);
    end
    chk("t6_sat_cnt", sat_cnt, 0);

    // sat_clr coinciding with a clipping beat leaving the pipe
    cfg_write(0, 8192, 14);
    send_beat(0, pack4(255, 255, 255, 255), 1'b0);
    wait_out(k);
    @(negedge clk);
    chk("t7_sat_pre", sat_cnt, 4);
    send_beat(0, pack4(255, -255, 255, -255), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(negedge clk);
    chk("t7_valid_at_clr", m_valid, 1);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("t7_sat_clr", sat_cnt, 0);

    repeat (3) @(posedge clk);
    chk("end_queue_empty", q_data.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
